// File: rtl/fifo_arbiter.sv
// Round-robin arbiter that moves words from four source FIFOs into four
// destination FIFOs. The destination is chosen by the top two bits of each
// word. Every output comes straight from a register.
module fifo_arbiter #(
  parameter int unsigned WORD_SIZE  = 10,
  parameter int unsigned NUM_QUEUES = 4
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic                            init,
  input  logic [NUM_QUEUES-1:0]           src_empty,
  input  logic [NUM_QUEUES-1:0]           src_error,
  input  logic [NUM_QUEUES-1:0]           src_valid,
  input  logic [NUM_QUEUES*WORD_SIZE-1:0] src_data,
  input  logic [NUM_QUEUES-1:0]           dst_almost_full,
  output logic [NUM_QUEUES-1:0]           src_pop,
  output logic [NUM_QUEUES-1:0]           dst_push,
  output logic [WORD_SIZE-1:0]            dst_data,
  output logic [2:0]                      state,
  output logic                            idle_out
);

  localparam int unsigned PtrW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;       // first queue examined by the next search
  logic [NUM_QUEUES-1:0] pop_q, pop_d;
  logic [NUM_QUEUES-1:0] push_q, push_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic                  idle_q, idle_d;

  logic                  fault;
  logic [NUM_QUEUES-1:0] eligible;
  logic                  grant_found;
  logic [PtrW-1:0]       grant_idx;
  logic [PtrW-1:0]       cand;
  logic [WORD_SIZE-1:0]  word;
  logic [1:0]            dest;

  // Fault detection, round-robin search and selection of the returning word.
  always_comb begin
    fault       = (src_error != '0) || ($countones(src_valid) > 1);
    // A queue popped last cycle still shows its stale empty flag, so skip it.
    eligible    = ~src_empty & ~pop_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      cand = ptr_q + PtrW'(i);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    word = '0;
    for (int k = 0; k < int'(NUM_QUEUES); k++) begin
      if (src_valid[k]) begin
        word = src_data[k*WORD_SIZE +: WORD_SIZE];
      end
    end
    dest = word[WORD_SIZE-1 -: 2];
  end

  // Next-state logic: init overrides everything, and faults override normal flow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        if (!init) state_d = StIdle;
      end
      StIdle: begin
        if (init)             state_d = StInit;
        else if (fault)       state_d = StError;
        else if (~&src_empty) state_d = StActive;
      end
      StActive: begin
        if (init)       state_d = StInit;
        else if (fault) state_d = StError;
        else if (&src_empty && (pop_q == '0) && (src_valid == '0)) state_d = StIdle;
      end
      StError: begin
        if (init) state_d = StInit;
      end
      default: state_d = StReset;
    endcase
  end

  // Output next values, computed for the state being entered so they line up with it.
  always_comb begin
    pop_d  = '0;
    push_d = '0;
    ptr_d  = ptr_q;
    data_d = data_q;
    idle_d = (state_d == StIdle);
    if (state_d == StInit) begin
      ptr_d = '0;
    end
    if (state_d == StActive) begin
      if (grant_found && (dst_almost_full == '0)) begin
        pop_d[grant_idx] = 1'b1;
        ptr_d            = grant_idx + PtrW'(1);
      end
      // A push already in flight finishes even after almost_full rises.
      if ((state_q == StActive) && (src_valid != '0)) begin
        push_d[dest] = 1'b1;
        data_d       = word;
      end
    end
  end

  // Registers; reset_L is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= StReset;
      ptr_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      data_q  <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      data_q  <= data_d;
      idle_q  <= idle_d;
    end
  end

  assign src_pop  = pop_q;
  assign dst_push = push_q;
  assign dst_data = data_q;
  assign state    = state_q;
  assign idle_out = idle_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter. Source FIFOs are emulated with queues.
// A behavioural model predicts the outputs every cycle, and hand-computed
// literals pin down the key scenarios.
module tb_fifo_arbiter;
  localparam int W = 10;

  logic           clk;
  logic           reset_L;
  logic           init;
  logic [3:0]     src_empty;
  logic [3:0]     src_error;
  logic [3:0]     src_valid;
  logic [4*W-1:0] src_data;
  logic [3:0]     dst_almost_full;
  logic [3:0]     src_pop;
  logic [3:0]     dst_push;
  logic [W-1:0]   dst_data;
  logic [2:0]     state;
  logic           idle_out;

  fifo_arbiter #(.WORD_SIZE(W), .NUM_QUEUES(4)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .src_empty       (src_empty),
    .src_error       (src_error),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .dst_almost_full (dst_almost_full),
    .src_pop         (src_pop),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .state           (state),
    .idle_out        (idle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Source FIFO emulation.
  logic [W-1:0] fq [4][$];
  logic [3:0]   pend_pop;

  // Model: the model's own copy of the queue contents, plus the words in flight.
  typedef struct {
    int           due;
    logic [W-1:0] word;
  } flight_t;
  logic [W-1:0] mq [4][$];
  flight_t      pipe[$];
  int           m_state;
  int           m_ptr;
  int           cyc;
  logic [3:0]   m_pop;
  logic [3:0]   m_push;
  logic [W-1:0] m_data;
  logic         m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v == (4'b0001 << i)) return i;
    end
    return -1;
  endfunction

  // Advance the model by one edge, using the inputs that the DUT sampled on that edge.
  task automatic model_step();
    int         nxt;
    logic [3:0] prev_pop;
    flight_t    f;
    cyc++;
    prev_pop = m_pop;
    m_pop    = '0;
    m_push   = '0;
    if (!reset_L) begin
      m_state = 0;
      m_ptr   = 0;
      m_data  = '0;
      m_idle  = 1'b0;
      pipe.delete();
      return;
    end
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (init) nxt = 1;
    else if (m_state == 1) nxt = 2;
    else if (m_state == 4) nxt = 4;
    else if (src_error != 0 || $countones(src_valid) > 1) nxt = 4;
    else if (m_state == 2 && src_empty != 4'hF) nxt = 3;
    else if (m_state == 3 && src_empty == 4'hF && prev_pop == 0 && src_valid == 0) nxt = 2;
    m_state = nxt;
    if (nxt == 1) m_ptr = 0;
    if (nxt == 3 && dst_almost_full == 0) begin
      for (int j = 0; j < 4; j++) begin
        int q;
        q = (m_ptr + j) % 4;
        if (!src_empty[q] && !prev_pop[q] && mq[q].size() > 0) begin
          m_pop[q] = 1'b1;
          m_ptr    = (q + 1) % 4;
          f.due    = cyc + 2;
          f.word   = mq[q].pop_front();
          pipe.push_back(f);
          break;
        end
      end
    end
    if (nxt != 3) begin
      pipe.delete();
    end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
      f = pipe.pop_front();
      m_push[f.word[W-1 -: 2]] = 1'b1;
      m_data = f.word;
    end
    m_idle = (nxt == 2);
  endtask

  // A pop requested during the previous cycle takes effect here, just like a real FIFO's rd_en.
  task automatic fifo_step();
    src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      if (pend_pop[k] && fq[k].size() > 0) begin
        src_valid[k]         = 1'b1;
        src_data[k*W +: W]   = fq[k].pop_front();
      end
      src_empty[k] = (fq[k].size() == 0);
    end
    pend_pop = src_pop;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    chk("state", 32'(state), m_state);
    chk("idle_out", 32'(idle_out), 32'(m_idle));
    chk("src_pop", 32'(src_pop), 32'(m_pop));
    chk("dst_push", 32'(dst_push), 32'(m_push));
    chk("dst_data", 32'(dst_data), 32'(m_data));
    fifo_step();
  endtask

  task automatic load(input int k, input logic [W-1:0] w);
    fq[k].push_back(w);
    mq[k].push_back(w);
    src_empty[k] = 1'b0;
  endtask

  task automatic wait_pop(input logic [3:0] mask, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle();
      if (src_pop == mask) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      if (idle_out && src_empty == 4'hF) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int         got[4];
    int         exp_order[4];
    int         pops;
    int         pushes;
    int         consec;
    logic [3:0] prevp;
    logic [3:0] acc;
    n_tests = 0;
    n_fail  = 0;
    reset_L = 1'b0;
    init    = 1'b1;
    src_empty = 4'hF;
    src_error = '0;
    src_valid = '0;
    src_data  = '0;
    dst_almost_full = '0;
    pend_pop = '0;
    m_state = 0;
    m_ptr   = 0;
    m_pop   = '0;
    m_push  = '0;
    m_data  = '0;
    m_idle  = 1'b0;
    cyc     = 0;
    exp_order = '{2, 3, 0, 1};

    // Reset, then bring-up with init held for two cycles.
    repeat (3) cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idle", 32'(idle_out), 32'd0);
    chk("rst_data", 32'(dst_data), 32'd0);
    reset_L = 1'b1;
    cycle(); chk("boot_s1", 32'(state), 32'd1);
    cycle(); chk("boot_s2", 32'(state), 32'd1);
    init = 1'b0;
    cycle(); chk("boot_s3", 32'(state), 32'd2);
    chk("boot_idle", 32'(idle_out), 32'd1);

    // Single word 0x2A5 in queue 2 should reach destination 2 two cycles after its pop.
    load(2, 10'h2A5);
    wait_pop(4'b0100, "q2_pop");
    cycle(); cycle();
    chk("q2_push", 32'(dst_push), 32'h4);
    chk("q2_data", 32'(dst_data), 32'h2A5);
    drain("drain_a");

    // Grant queue 1 first, then fill every queue: the order must be 2,3,0,1.
    load(1, 10'h1AB);
    wait_pop(4'b0010, "q1_pop");
    load(0, 10'h0C1); load(1, 10'h155); load(2, 10'h23C); load(3, 10'h3F0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      got[i] = idx_of(src_pop);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), got[i], exp_order[i]);
    drain("drain_b");

    // Three words in queue 0 alone: pops only on alternate cycles.
    load(0, 10'h011); load(0, 10'h122); load(0, 10'h233);
    pops = 0; pushes = 0; consec = 0; prevp = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (src_pop != 0) pops++;
      if (src_pop != 0 && prevp != 0) consec++;
      if (dst_push != 0) pushes++;
      prevp = src_pop;
    end
    chk("alt_pops", pops, 3);
    chk("alt_consec", consec, 0);
    chk("alt_pushes", pushes, 3);
    chk("alt_idle", 32'(idle_out), 32'd1);

    // almost_full rises with a word in flight: that push completes, and new pops stop.
    load(3, 10'h1D0); load(3, 10'h1D1);
    wait_pop(4'b1000, "af_pop");
    dst_almost_full = 4'b0010;
    pops = 0; pushes = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (src_pop != 0) pops++;
      if (dst_push == 4'b0010) begin
        pushes++;
        chk("af_data", 32'(dst_data), 32'h1D0);
      end
    end
    chk("af_no_pop", pops, 0);
    chk("af_push_done", pushes, 1);
    dst_almost_full = '0;
    wait_pop(4'b1000, "af_resume");
    drain("drain_d");

    // A source error drops the word in flight; init brings the block back.
    load(3, 10'h3A1); load(3, 10'h3A2); load(3, 10'h3A3);
    wait_pop(4'b1000, "err_pop");
    src_error = 4'b1000;
    cycle(); chk("err_state", 32'(state), 32'd4);
    src_error = '0;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      acc = acc | src_pop | dst_push;
    end
    chk("err_quiet", 32'(acc), 32'd0);
    chk("err_hold", 32'(state), 32'd4);
    init = 1'b1;
    cycle(); chk("err_init", 32'(state), 32'd1);
    init = 1'b0;
    cycle(); chk("err_idle", 32'(state), 32'd2);
    drain("drain_e");

    // Reset in mid-operation clears the outputs and sends the pointer back to queue 0.
    load(2, 10'h2B1); load(2, 10'h2B2);
    wait_pop(4'b0100, "rst_pop");
    reset_L = 1'b0;
    cycle();
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_pop", 32'(src_pop), 32'd0);
    chk("mid_rst_data", 32'(dst_data), 32'd0);
    load(1, 10'h111); load(3, 10'h333);
    cycle();
    chk("mid_rst_push", 32'(dst_push), 32'd0);
    reset_L = 1'b1;
    cycle(); chk("rel_init", 32'(state), 32'd1);
    cycle(); chk("rel_idle", 32'(state), 32'd2);
    cycle(); chk("rel_first_grant", idx_of(src_pop), 1);
    drain("drain_r");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 10: bit width of each word.
REQ-002 SHALL have parameter NUM_QUEUES, default 4: number of source and destination FIFOs (fixed at 4).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_L  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port init  input  1  re-initialise request, active-high.
REQ-006 SHALL have port src_empty  input  4  empty_flag of each source FIFO.
REQ-007 SHALL have port src_error  input  4  error_flag of each source FIFO.
REQ-008 SHALL have port src_valid  input  4  valid of each source FIFO, one cycle after its pop.
REQ-009 SHALL have port src_data  input  4*WORD_SIZE  data_out of each source FIFO; queue k is bits [k*WORD_SIZE +: WORD_SIZE].
REQ-010 SHALL have port dst_almost_full  input  4  almost_full_flag of each destination FIFO.
REQ-011 SHALL have port src_pop  output  4  rd_en to each source FIFO.
REQ-012 SHALL have port dst_push  output  4  wr_en to each destination FIFO.
REQ-013 SHALL have port dst_data  output  WORD_SIZE  data_in shared by all destination FIFOs.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port idle_out  output  1  high while state is IDLE.

Function
REQ-016 SHALL implement states RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; all outputs registered.
REQ-017 SHALL go RESET->INIT on the first edge with reset_L high.
REQ-018 SHALL stay in INIT while init=1; INIT->IDLE when init=0.
REQ-019 SHALL go from IDLE, ACTIVE or ERROR to INIT whenever init=1 (priority over all but reset).
REQ-020 SHALL go from IDLE or ACTIVE to ERROR when any src_error bit=1, or when more than one src_valid bit=1 in a cycle.
REQ-021 SHALL leave ERROR only via init or reset; in ERROR, src_pop=0 and dst_push=0, and in-flight words are dropped.
REQ-022 SHALL go IDLE->ACTIVE when any src_empty bit=0; ACTIVE->IDLE when all src_empty=1 and no pop is in flight (no src_pop last cycle, no src_valid this cycle).
REQ-023 SHALL, in ACTIVE only, assert at most one src_pop bit per cycle, and only when every dst_almost_full bit=0.
REQ-024 SHALL grant round-robin: search starts at the queue after the last granted one and skips empty queues; the pointer resets to queue 0 in RESET/INIT.
REQ-025 SHALL NOT pop queue k in the cycle after popping queue k (empty-flag lag); the next non-empty queue is granted instead, or none.
REQ-026 SHALL route by destination field d = src_data word bits [WORD_SIZE-1:WORD_SIZE-2].
REQ-027 SHALL, when src_valid[k]=1 at edge N, present dst_data = queue k word and dst_push[d]=1 for cycle N+1 only; pop-to-push latency is 2 cycles.
REQ-028 SHALL still complete a push already in flight when dst_almost_full rises; only new pops stop (destination threshold leaves at least 2 free slots).
REQ-029 SHALL ignore src_valid outside ACTIVE and hold dst_data when dst_push=0.

Reset
REQ-030 SHALL, while reset_L=0 at an edge: state=RESET, src_pop=0, dst_push=0, dst_data=0, idle_out=0, round-robin pointer=0, mid-operation included, with in-flight words discarded.

Verification
REQ-031 Release reset with init=1 for 2 cycles, then 0 -> state 0,1,1,2 and idle_out=1.
REQ-032 Queue 2 holds 0x2A5 (d=2) -> src_pop[2] at N, dst_push[2]=1 and dst_data=0x2A5 at N+2.
REQ-033 All four queues non-empty, last grant queue 1 -> pop order 2,3,0,1 on consecutive cycles.
REQ-034 Only queue 0 non-empty with 3 words -> pops on alternate cycles only, 3 pushes, then return to IDLE.
REQ-035 dst_almost_full[1]=1 with an in-flight word -> that push completes, no further src_pop until the flag clears.
REQ-036 src_error[3]=1 in ACTIVE -> ERROR (4) next cycle, no pops or pushes; init pulse -> INIT, then IDLE.
